// File: rtl/fp32_reduce_seq.sv
// fp32_reduce_seq
//   Sequential FP32 reduction controller placed in front of a pipelined FP32
//   adder. Elements of a vector (framed by in_last) are summed one at a time:
//   the running accumulator and the new element are presented to the adder,
//   the adder latency is waited out, and the result becomes the new
//   accumulator. One sum per vector is offered on a valid/ready output.
//   Operand values are never inspected; all FP corner cases are the adder's.
//
// Parameters
//   ADD_LAT : adder register stages from operand change to valid result (>= 1)
//   CNT_W   : width of the saturating element counter
//
// Ports
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    : element handshake; in_data element, in_last marks end
//   add_a/add_b          : registered adder operands (accumulator / element)
//   add_o                : adder result
//   out_valid/out_ready  : sum handshake; out_data sum, out_count element count
module fp32_reduce_seq #(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned WCNT_W = $clog2(ADD_LAT + 2);
  localparam logic [WCNT_W-1:0] LAT_FULL  = WCNT_W'(ADD_LAT);
  localparam logic [WCNT_W-1:0] LAT_EARLY = WCNT_W'(ADD_LAT - 1);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACC   = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  state_e            state_q;
  logic [31:0]       acc_q;
  logic [31:0]       add_a_q;
  logic [31:0]       add_b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              last_q;
  logic              pend_q;
  logic              out_valid_q;
  logic [31:0]       out_data_q;
  logic [CNT_W-1:0]  out_count_q;

  logic              accept;
  logic [CNT_W-1:0]  cnt_d;

  assign in_ready  = !rst && (state_q == FIRST || state_q == ACC);
  assign accept    = in_valid && in_ready;
  assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Mid-vector, WAIT is left one cycle early and the adder result is taken
  // in ACC (pend_q): captured into acc, or forwarded straight to add_a if an
  // element is accepted on that same edge. This lets the next accept land on
  // the capture edge (E+ADD_LAT+1). The final element captures in WAIT itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FIRST;
      acc_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      last_q      <= 1'b0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        FIRST: begin
          if (accept) begin
            acc_q  <= in_data;
            cnt_q  <= CNT_W'(1);
            pend_q <= 1'b0;
            if (in_last) begin
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              out_count_q <= CNT_W'(1);
              state_q     <= OUT;
            end else begin
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          if (pend_q) begin
            acc_q  <= add_o;
            pend_q <= 1'b0;
          end
          if (accept) begin
            add_a_q <= pend_q ? add_o : acc_q;
            add_b_q <= in_data;
            last_q  <= in_last;
            cnt_q   <= cnt_d;
            wcnt_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          wcnt_q <= wcnt_q + WCNT_W'(1);
          if (last_q && wcnt_q == LAT_FULL) begin
            acc_q       <= add_o;
            out_valid_q <= 1'b1;
            out_data_q  <= add_o;
            out_count_q <= cnt_q;
            state_q     <= OUT;
          end else if (!last_q && wcnt_q == LAT_EARLY) begin
            pend_q  <= 1'b1;
            state_q <= ACC;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= FIRST;
          end
        end
        default: state_q <= FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_reduce_seq.sv
// tb_fp32_reduce_seq
//   Drives two instances with identical stimulus: the default configuration
//   and a CNT_W=2 copy whose element counter saturates at 3. Each instance
//   has its own behavioural 2-stage adder. Expected sums/counts are queued
//   when a vector is driven and compared when the sum handshake occurs.
module tb_fp32_reduce_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  s_in_ready;
  logic [31:0] add_a,     s_add_a;
  logic [31:0] add_b,     s_add_b;
  logic [31:0] add_o,     s_add_o;
  logic        out_valid, s_out_valid;
  logic [31:0] out_data,  s_out_data;
  logic [15:0] out_count;
  logic [1:0]  s_out_count;

  fp32_reduce_seq #(.ADD_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_o(add_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  fp32_reduce_seq #(.ADD_LAT(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(s_add_a), .add_b(s_add_b), .add_o(s_add_o),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_count(s_out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FP32 <-> real for normal numbers and zero; all test sums are exact.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural adder: result valid ADD_LAT=2 edges after operands change.
  logic [31:0] st1, st2, s_st1, s_st2;
  always_ff @(posedge clk) begin
    st1   <= r2f(f2r(add_a) + f2r(add_b));
    st2   <= st1;
    s_st1 <= r2f(f2r(s_add_a) + f2r(s_add_b));
    s_st2 <= s_st1;
  end
  assign add_o   = st2;
  assign s_add_o = s_st2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_data_q [$];
  int          exp_cnt_q  [$];
  logic [31:0] exp_data_s [$];
  int          exp_cnt_s  [$];

  // Scoreboard: sampled just after the falling edge, when all drive is settled.
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_data_q.size() == 0) check("extra_out", 32'd1, 32'd0);
      else begin
        check("out_data", out_data, exp_data_q.pop_front());
        check("out_count", 32'(out_count), 32'(exp_cnt_q.pop_front()));
      end
    end
    if (!rst && s_out_valid && out_ready) begin
      if (exp_data_s.size() == 0) check("s_extra_out", 32'd1, 32'd0);
      else begin
        check("s_out_data", s_out_data, exp_data_s.pop_front());
        check("s_out_count", 32'(s_out_count), 32'(exp_cnt_s.pop_front()));
      end
    end
  end

  logic [31:0] vec [$];

  task automatic wait_accept(output int edge_idx);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("accept_seen", 32'(in_ready), 32'd1);
    edge_idx = cyc + 1;
    @(negedge clk);
  endtask

  task automatic send_vec(input logic [31:0] sum, output int first_edge);
    int n = vec.size();
    int e;
    exp_data_q.push_back(sum);
    exp_cnt_q.push_back(n);
    exp_data_s.push_back(sum);
    exp_cnt_s.push_back(n > 3 ? 3 : n);
    first_edge = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      in_last  = (i == n - 1);
      wait_accept(e);
      if (i == 0) first_edge = e;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    int g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int t0, h, e;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    rst = 1'b0;
    #1 check("rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // 1 + 2 + 3
    vec = '{32'h3F800000, 32'h40000000, 32'h40400000};
    send_vec(32'h40C00000, t0);
    wait_out();
    check("t1_latency", 32'(cyc - t0), 32'd7);
    @(negedge clk);

    // single element bypasses the adder
    vec = '{32'hC0490FDB};
    send_vec(32'hC0490FDB, t0);
    wait_out();
    check("t2_latency", 32'(cyc - t0), 32'd0);
    check("t2_add_a", add_a, 32'h40400000);
    check("t2_add_b", add_b, 32'h40400000);
    @(negedge clk);

    // 1.0 + -1.0: operands stable, no accept while waiting
    vec = '{32'h3F800000, 32'hBF800000};
    send_vec(32'h00000000, t0);
    for (int g = 0; g < 20 && !out_valid; g++) begin
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_add_a", add_a, 32'h3F800000);
      check("t3_add_b", add_b, 32'hBF800000);
      @(negedge clk);
    end
    wait_out();
    @(negedge clk);

    // output back-pressure, then immediate next-vector accept
    out_ready = 1'b0;
    vec = '{32'h40000000, 32'h40400000};
    send_vec(32'h40A00000, t0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_data", out_data, 32'h40A00000);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    h = cyc + 1;
    vec = '{32'h3F800000, 32'h3F800000};
    send_vec(32'h40000000, t0);
    check("t4_next_accept", 32'(t0 - h), 32'd1);
    wait_out();
    @(negedge clk);

    // reset during WAIT of a 4-element vector
    in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
    wait_accept(e);
    wait_accept(e);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_out_data", out_data, 32'd0);
    check("t5_add_a", add_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t5_first", 32'(in_ready), 32'd1);
    @(negedge clk);
    vec = '{32'h40000000, 32'h40000000};
    send_vec(32'h40800000, t0);
    wait_out();
    @(negedge clk);

    // five ones: small counter saturates at 3
    vec = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    send_vec(32'h40A00000, t0);
    wait_out();
    repeat (3) @(negedge clk);

    check("sb_empty", 32'(exp_data_q.size()), 32'd0);
    check("s_sb_empty", 32'(exp_data_s.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
